// File: rtl/dft_test_sequencer.sv
// dft_test_sequencer
//   Runs one DFT test per start pulse against the scan chain / BIST engine.
//   Scan mode shifts a pattern in LSB first, captures for one cycle, shifts
//   the response out (first bit out lands in bit 0) and compares it with the
//   expected value. BIST mode pulses bist_start and waits for bist_done,
//   bounded by a BIST_TIMEOUT-cycle timeout.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   start, mode         start request (IDLE only); 0 = scan, 1 = BIST
//   pat_in, exp_in      scan stimulus / expected response, captured with start
//   scan_so             serial response from the DUT chain
//   bist_done, bist_fail BIST engine status
//   scan_en, scan_si    scan chain control / serial stimulus
//   bist_start          one-cycle BIST launch pulse
//   busy, done          test in progress / one-cycle completion pulse
//   pass, timeout       result flags, held until the next start
//   resp_out            captured scan response, held until the next start
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | waiting for start
// S_LOAD     | shifting pattern into the chain (CHAIN_LEN cycles)
// S_CAPTURE  | single functional capture cycle
// S_UNLOAD   | shifting response out of the chain (CHAIN_LEN cycles)
// S_COMPARE  | compare response with expected, register results
// S_BIST_RUN | waiting for bist_done or timeout
// S_FIN      | done pulse cycle
module dft_test_sequencer #(
  parameter int CHAIN_LEN    = 16,
  parameter int BIST_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic                 scan_so,
  input  logic                 bist_done,
  input  logic                 bist_fail,
  output logic                 scan_en,
  output logic                 scan_si,
  output logic                 bist_start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CHAIN_LEN-1:0] resp_out
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CAPTURE, S_UNLOAD, S_COMPARE, S_BIST_RUN, S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_si_q, scan_si_d;
  logic                 bist_start_q, bist_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [CHAIN_LEN-1:0] resp_out_q, resp_out_d;

  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    exp_d        = exp_q;
    resp_d       = resp_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    scan_en_d    = 1'b0;
    scan_si_d    = 1'b0;
    bist_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    resp_out_d   = resp_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // bit 0 goes out on the first LOAD cycle, so the shift register
          // starts already shifted by one
          pat_d      = pat_in >> 1;
          exp_d      = exp_in;
          resp_d     = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          resp_out_d = '0;
          busy_d     = 1'b1;
          if (mode) begin
            state_d      = S_BIST_RUN;
            bist_start_d = 1'b1;
            to_cnt_d     = TO_W'(BIST_TIMEOUT - 1);
          end else begin
            state_d   = S_LOAD;
            scan_en_d = 1'b1;
            scan_si_d = pat_in[0];
            bit_cnt_d = CNT_W'(CHAIN_LEN - 1);
          end
        end
      end
      S_LOAD: begin
        if (bit_cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          scan_en_d = 1'b1;
          scan_si_d = pat_q[0];
          pat_d     = pat_q >> 1;
        end
      end
      S_CAPTURE: begin
        state_d   = S_UNLOAD;
        scan_en_d = 1'b1;
        bit_cnt_d = CNT_W'(CHAIN_LEN - 1);
      end
      S_UNLOAD: begin
        // written as a wide shift so CHAIN_LEN=1 needs no special case
        resp_d = CHAIN_LEN'({scan_so, resp_q} >> 1);
        if (bit_cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          scan_en_d = 1'b1;
        end
      end
      S_COMPARE: begin
        pass_d     = (resp_q == exp_q);
        resp_out_d = resp_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_FIN;
      end
      S_BIST_RUN: begin
        // bist_done takes priority over the terminal count
        if (bist_done) begin
          pass_d    = ~bist_fail;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_FIN;
        end else if (to_cnt_q == '0) begin
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      exp_q        <= '0;
      resp_q       <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      scan_en_q    <= 1'b0;
      scan_si_q    <= 1'b0;
      bist_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      resp_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      exp_q        <= exp_d;
      resp_q       <= resp_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      scan_en_q    <= scan_en_d;
      scan_si_q    <= scan_si_d;
      bist_start_q <= bist_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      resp_out_q   <= resp_out_d;
    end
  end

  assign scan_en    = scan_en_q;
  assign scan_si    = scan_si_q;
  assign bist_start = bist_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign resp_out   = resp_out_q;

endmodule

// File: tb/tb_dft_test_sequencer.sv
// Testbench for dft_test_sequencer: table of directed tests, randomized
// tests, reset aborts. Expected per-cycle outputs are derived from the
// test timeline (cycle index after the start edge), not from any state.
module tb_dft_test_sequencer;

  localparam int CL = 4;
  localparam int T  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [CL-1:0] pat_in = '0;
  logic [CL-1:0] exp_in = '0;
  logic          scan_so;
  logic          bist_done = 1'b0;
  logic          bist_fail = 1'b0;
  logic          scan_en, scan_si, bist_start, busy, done, pass, timeout;
  logic [CL-1:0] resp_out;

  logic [CL-1:0] chain;
  logic [CL-1:0] cap_mask = '0;
  logic [6+CL:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  dft_test_sequencer #(.CHAIN_LEN(CL), .BIST_TIMEOUT(T), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .pat_in(pat_in), .exp_in(exp_in), .scan_so(scan_so),
    .bist_done(bist_done), .bist_fail(bist_fail),
    .scan_en(scan_en), .scan_si(scan_si), .bist_start(bist_start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .resp_out(resp_out)
  );

  always #5 clk = ~clk;

  // Scan chain model: shifts toward bit 0 when enabled, otherwise a capture
  // XORs cap_mask into the chain (mask 0 = pure echo).
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_si, chain[CL-1:1]};
    else         chain <= chain ^ cap_mask;
  end
  assign scan_so = chain[0];

  assign obs = {scan_en, scan_si, bist_start, busy, done, pass, timeout, resp_out};

  typedef struct {
    string         name;
    logic          mode;
    logic [CL-1:0] pat;
    logic [CL-1:0] expv;
    logic [CL-1:0] mask;
    int            dly;      // BIST: cycle index where bist_done rises, -1 never
    logic          fail;
    int            noise;    // 0 quiet, 1 start held high while busy, 2 random start
    int            abort_at; // cycle index at which reset is asserted, -1 never
  } vec_t;

  function automatic vec_t mk(string n, logic m, logic [CL-1:0] p, logic [CL-1:0] e,
                              logic [CL-1:0] msk, int d, logic f, int nz, int ab);
    vec_t v;
    v.name = n; v.mode = m; v.pat = p; v.expv = e; v.mask = msk;
    v.dly = d; v.fail = f; v.noise = nz; v.abort_at = ab;
    return v;
  endfunction

  task automatic check(string name, int k, logic [6+CL:0] act, logic [6+CL:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b required %b {scan_en,scan_si,bist_start,busy,done,pass,timeout,resp_out}",
               name, k, act, expv);
    end
  endtask

  // Expected outputs k cycles after the start edge; kd is the done cycle.
  function automatic logic [6+CL:0] expect_at(logic m, logic [CL-1:0] p, int k, int kd,
                                               logic fp, logic ft, logic [CL-1:0] fr);
    logic [CL-1:0] sh;
    logic en, si, bs, bz, dn, ps, to;
    logic [CL-1:0] r;
    sh = p >> k;
    if (!m) begin
      en = (k < CL) || (k > CL && k <= 2 * CL);
      si = (k < CL) ? sh[0] : 1'b0;
      bs = 1'b0;
    end else begin
      en = 1'b0;
      si = 1'b0;
      bs = (k == 0);
    end
    bz = (k < kd);
    dn = (k == kd);
    ps = (k >= kd) ? fp : 1'b0;
    to = (k >= kd) ? ft : 1'b0;
    r  = (k >= kd) ? fr : '0;
    return {en, si, bs, bz, dn, ps, to, r};
  endfunction

  task automatic do_abort(string name);
    rst_n = 1'b0;
    start = 1'b0;
    bist_done = 1'b0;
    #1;
    check({name, "_rst_async"}, 0, obs, '0);
    @(negedge clk);
    check({name, "_rst_hold"}, 1, obs, '0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check({name, "_idle_after_rst"}, j, obs, '0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_txn(vec_t v);
    int kd;
    logic fp, ft;
    logic [CL-1:0] fr, rsp;
    rsp = v.pat ^ v.mask;
    if (!v.mode) begin
      kd = 2 * CL + 2;
      fr = rsp;
      fp = (rsp == v.expv);
      ft = 1'b0;
    end else begin
      fr = '0;
      if (v.dly >= 0 && v.dly <= T - 1) begin
        kd = v.dly + 1;
        fp = ~v.fail;
        ft = 1'b0;
      end else begin
        kd = T;
        fp = 1'b0;
        ft = 1'b1;
      end
    end
    mode      = v.mode;
    pat_in    = v.pat;
    exp_in    = v.expv;
    cap_mask  = v.mask;
    bist_fail = v.fail;
    bist_done = 1'b0;
    start     = 1'b1;
    for (int k = 0; k <= kd + 1; k++) begin
      @(negedge clk);
      check(v.name, k, obs, expect_at(v.mode, v.pat, k, kd, fp, ft, fr));
      if (k == v.abort_at) begin
        do_abort(v.name);
        return;
      end
      if (k > kd)            start = 1'b0;
      else if (v.noise == 1) start = 1'b1;
      else if (v.noise == 2) start = 1'($urandom_range(0, 1));
      else                   start = 1'b0;
      if (k <= kd) begin
        pat_in = CL'($urandom);
        exp_in = CL'($urandom);
        mode   = 1'($urandom_range(0, 1));
      end
      bist_done = v.mode && v.dly >= 0 && k >= v.dly && k <= kd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    tbl.push_back(mk("scan_pass",        1'b0, 4'b1011, 4'b1011, 4'b0000, -1, 1'b0, 0, -1));
    tbl.push_back(mk("scan_fail",        1'b0, 4'b1011, 4'b1010, 4'b0000, -1, 1'b0, 0, -1));
    tbl.push_back(mk("scan_capture_xor", 1'b0, 4'b0110, 4'b0011, 4'b0101, -1, 1'b0, 0, -1));
    tbl.push_back(mk("bist_pass",        1'b1, 4'b0000, 4'b0000, 4'b0000,  5, 1'b0, 0, -1));
    tbl.push_back(mk("bist_fail",        1'b1, 4'b0000, 4'b0000, 4'b0000,  5, 1'b1, 0, -1));
    tbl.push_back(mk("bist_timeout",     1'b1, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0, 0, -1));
    tbl.push_back(mk("bist_done_on_tc",  1'b1, 4'b0000, 4'b0000, 4'b0000,  7, 1'b0, 0, -1));
    tbl.push_back(mk("bist_tc_fail",     1'b1, 4'b0000, 4'b0000, 4'b0000,  7, 1'b1, 0, -1));
    tbl.push_back(mk("bist_done_first",  1'b1, 4'b0000, 4'b0000, 4'b0000,  0, 1'b0, 0, -1));
    tbl.push_back(mk("start_while_busy", 1'b0, 4'b1001, 4'b1001, 4'b0000, -1, 1'b0, 1, -1));
    tbl.push_back(mk("bist_start_busy",  1'b1, 4'b0000, 4'b0000, 4'b0000,  3, 1'b0, 1, -1));
    tbl.push_back(mk("scan_pass_again",  1'b0, 4'b1111, 4'b1111, 4'b0000, -1, 1'b0, 0, -1));
    tbl.push_back(mk("abort_load",       1'b0, 4'b1101, 4'b1101, 4'b0000, -1, 1'b0, 0,  2));
    tbl.push_back(mk("scan_after_abort", 1'b0, 4'b0111, 4'b0111, 4'b0000, -1, 1'b0, 0, -1));
    tbl.push_back(mk("abort_unload",     1'b0, 4'b1011, 4'b1011, 4'b0000, -1, 1'b0, 0,  7));
    tbl.push_back(mk("bist_after_abort", 1'b1, 4'b0000, 4'b0000, 4'b0000,  2, 1'b0, 0, -1));
    tbl.push_back(mk("abort_bist",       1'b1, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0, 0,  3));

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_init", 0, obs, '0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("idle_no_start", j, obs, '0);
    end

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      logic m, f;
      logic [CL-1:0] p, msk, e;
      int d;
      m   = 1'($urandom_range(0, 1));
      p   = CL'($urandom);
      msk = CL'($urandom);
      e   = ($urandom_range(0, 1) == 1) ? (p ^ msk) : CL'($urandom);
      d   = int'($urandom_range(0, T + 1));
      if ($urandom_range(0, 3) == 0) d = -1;
      f   = 1'($urandom_range(0, 1));
      run_txn(mk("random", m, p, e, msk, d, f, 2 * int'($urandom_range(0, 1)), -1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
